// File: rtl/i2s_dsd_mode_ctrl.sv
// Mode sequencer for the I2S/DSD front end: frame-lock supervision of LRCK,
// synchronised DSD_ON request handling and mute/clear sequencing of the datapath.
module i2s_dsd_mode_ctrl #(
  parameter int unsigned HALF_BCK    = 32,
  parameter int unsigned LOCK_HALVES = 8,
  parameter int unsigned MUTE_CYCLES = 64,
  parameter int unsigned CLR_CYCLES  = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       I2S_BCKorDSDCLK,
  input  logic       I2S_RST,
  input  logic       I2S_LRCKorDSD2,
  input  logic       DSD_ON,
  output logic       PATH_DSD,
  output logic       MOD_EN,
  output logic       MOD_CLR,
  output logic       MUTE,
  output logic       LOCKED,
  output logic       FRAME_ERR,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACQUIRE   = 3'd1,
    ST_PCM_RUN   = 3'd2,
    ST_MUTE_DOWN = 3'd3,
    ST_CLEAR     = 3'd4,
    ST_DSD_RUN   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BCK - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(2 * HALF_BCK - 1);
  localparam logic [CNT_W-1:0] LOCK_N    = CNT_W'(LOCK_HALVES);
  localparam logic [CNT_W-1:0] MUTE_LOAD = CNT_W'(MUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic clk;
  logic rst_n;
  assign clk   = I2S_BCKorDSDCLK;
  assign rst_n = I2S_RST;

  state_t           state, state_nxt;
  logic             tgt, tgt_nxt;
  logic             sync1, req, lrck_d;
  logic [CNT_W-1:0] hcnt, good, dcnt;
  logic             primed;
  logic             lr_edge, chk_active, good_ev, bad_ev, tmo;
  logic             ferr_nxt, path_nxt;

  assign STATE = state;

  // DSD_ON two-flop synchroniser and one-cycle LRCK delay for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      req    <= 1'b0;
      lrck_d <= 1'b0;
    end else begin
      sync1  <= DSD_ON;
      req    <= sync1;
      lrck_d <= I2S_LRCKorDSD2;
    end
  end

  // Frame events: primed edge at the expected count is good, anything else or a timeout is bad
  always_comb begin
    lr_edge    = I2S_LRCKorDSD2 ^ lrck_d;
    chk_active = (state == ST_IDLE) || (state == ST_ACQUIRE) || (state == ST_PCM_RUN);
    tmo        = chk_active && !lr_edge && (hcnt == TMO_LAST);
    good_ev    = chk_active && lr_edge && primed && (hcnt == HALF_LAST);
    bad_ev     = (chk_active && lr_edge && primed && (hcnt != HALF_LAST)) || tmo;
  end

  // Half-period counter, primed flag and consecutive-good counter; cleared outside PCM states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt   <= '0;
      primed <= 1'b0;
      good   <= '0;
    end else if (!chk_active) begin
      hcnt   <= '0;
      primed <= 1'b0;
      good   <= '0;
    end else begin
      if (lr_edge)              hcnt <= '0;
      else if (hcnt != CNT_MAX) hcnt <= hcnt + CNT_ONE;
      if (tmo)                  primed <= 1'b0;
      else if (lr_edge)         primed <= 1'b1;
      if (bad_ev)                             good <= '0;
      else if (good_ev && (good != LOCK_N))   good <= good + CNT_ONE;
    end
  end

  // State and latched target register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      tgt   <= 1'b0;
    end else begin
      state <= state_nxt;
      tgt   <= tgt_nxt;
    end
  end

  // Next-state, target and frame-error decode
  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    ferr_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        tgt_nxt   = req;
        state_nxt = req ? ST_CLEAR : ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (req) begin
          state_nxt = ST_CLEAR;
          tgt_nxt   = 1'b1;
        end else if (good == LOCK_N) begin
          state_nxt = ST_CLEAR;
          tgt_nxt   = 1'b0;
        end
      end
      ST_PCM_RUN: begin
        if (bad_ev) begin
          state_nxt = ST_ACQUIRE;
          ferr_nxt  = 1'b1;
        end else if (req) begin
          state_nxt = ST_MUTE_DOWN;
          tgt_nxt   = 1'b1;
        end
      end
      ST_MUTE_DOWN: begin
        if (dcnt == '0) state_nxt = tgt ? ST_CLEAR : ST_ACQUIRE;
      end
      ST_CLEAR: begin
        if (dcnt == '0) state_nxt = tgt ? ST_DSD_RUN : ST_PCM_RUN;
      end
      ST_DSD_RUN: begin
        if (!req) begin
          state_nxt = ST_MUTE_DOWN;
          tgt_nxt   = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    path_nxt = PATH_DSD;
    if (state_nxt != state) begin
      if ((state_nxt == ST_CLEAR) && tgt_nxt) path_nxt = 1'b1;
      else if (state_nxt == ST_ACQUIRE)       path_nxt = 1'b0;
    end
  end

  // Dwell counter loads on entry to MUTE_DOWN/CLEAR and counts down to the exit cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= '0;
    end else if (state_nxt != state) begin
      if (state_nxt == ST_MUTE_DOWN)  dcnt <= MUTE_LOAD;
      else if (state_nxt == ST_CLEAR) dcnt <= CLR_LOAD;
    end else if (dcnt != '0) begin
      dcnt <= dcnt - CNT_ONE;
    end
  end

  // Registered Moore outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PATH_DSD  <= 1'b0;
      MOD_EN    <= 1'b0;
      MOD_CLR   <= 1'b0;
      MUTE      <= 1'b1;
      LOCKED    <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      PATH_DSD  <= path_nxt;
      MOD_EN    <= (state_nxt == ST_PCM_RUN) || ((state_nxt == ST_MUTE_DOWN) && tgt_nxt);
      MOD_CLR   <= (state_nxt == ST_CLEAR);
      MUTE      <= !((state_nxt == ST_PCM_RUN) || (state_nxt == ST_DSD_RUN));
      LOCKED    <= (state_nxt == ST_PCM_RUN);
      FRAME_ERR <= ferr_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_dsd_mode_ctrl.sv
// Scoreboard bench for i2s_dsd_mode_ctrl: a behavioural model queues the expected
// output word per cycle, a monitor compares it against the DUT on the falling edge.
module tb_i2s_dsd_mode_ctrl;

  localparam int HALF  = 32;
  localparam int LOCKN = 8;
  localparam int MUTEN = 64;
  localparam int CLRN  = 16;
  localparam int HMAX  = 255;
  localparam logic [8:0] RST_VEC = 9'h004;  // {state, path, en, clr, mute, locked, ferr}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lrck = 1'b0;
  logic dsd_on = 1'b0;
  logic path_dsd, mod_en, mod_clr, mute, locked, frame_err;
  logic [2:0] state_o;
  logic [8:0] act;

  int checks = 0;
  int errors = 0;

  i2s_dsd_mode_ctrl dut (
    .I2S_BCKorDSDCLK(clk),
    .I2S_RST        (rst_n),
    .I2S_LRCKorDSD2 (lrck),
    .DSD_ON         (dsd_on),
    .PATH_DSD       (path_dsd),
    .MOD_EN         (mod_en),
    .MOD_CLR        (mod_clr),
    .MUTE           (mute),
    .LOCKED         (locked),
    .FRAME_ERR      (frame_err),
    .STATE          (state_o)
  );

  always #5 clk = ~clk;

  assign act = {state_o, path_dsd, mod_en, mod_clr, mute, locked, frame_err};

  // ---------------- behavioural reference model ----------------
  logic [8:0] exp_q[$];
  int  m_st, m_tgt, m_dwell, m_hc, m_good;
  bit  m_primed, m_s1, m_req, m_ld, m_path;

  always @(posedge clk or negedge rst_n) begin : model
    int nst, ntgt;
    bit ferr, ev, active, g, b;
    if (!rst_n) begin
      m_st = 0; m_tgt = 0; m_dwell = 0; m_hc = 0; m_good = 0;
      m_primed = 0; m_s1 = 0; m_req = 0; m_ld = 0; m_path = 0;
      exp_q.delete();
      exp_q.push_back(RST_VEC);
    end else begin
      ev     = (lrck != m_ld);
      active = (m_st <= 2);
      g = active && ev && m_primed && (m_hc == HALF - 1);
      b = active && ((ev && m_primed && (m_hc != HALF - 1)) || (!ev && (m_hc == 2 * HALF - 1)));

      nst = m_st; ntgt = m_tgt; ferr = 0;
      case (m_st)
        0: begin ntgt = m_req; nst = m_req ? 4 : 1; end
        1: if (m_req) begin nst = 4; ntgt = 1; end
           else if (m_good == LOCKN) begin nst = 4; ntgt = 0; end
        2: if (b) begin nst = 1; ferr = 1; end
           else if (m_req) begin nst = 3; ntgt = 1; end
        3: if (m_dwell == 1) nst = (m_tgt == 1) ? 4 : 1;
        4: if (m_dwell == 1) nst = (m_tgt == 1) ? 5 : 2;
        5: if (!m_req) begin nst = 3; ntgt = 0; end
        default: nst = 0;
      endcase

      // frame checker bookkeeping
      if (!active) begin
        m_hc = 0; m_primed = 0; m_good = 0;
      end else begin
        if (b) m_good = 0;
        else if (g && m_good < LOCKN) m_good = m_good + 1;
        if (!ev && m_hc == 2 * HALF - 1) m_primed = 0;
        else if (ev) m_primed = 1;
        m_hc = ev ? 0 : ((m_hc < HMAX) ? m_hc + 1 : HMAX);
      end

      // remaining-cycles dwell and path selection on entry
      if (nst != m_st) begin
        if (nst == 3) m_dwell = MUTEN;
        else if (nst == 4) m_dwell = CLRN;
        if (nst == 4 && ntgt == 1) m_path = 1;
        else if (nst == 1) m_path = 0;
      end else if (m_st == 3 || m_st == 4) begin
        m_dwell = m_dwell - 1;
      end

      m_req = m_s1;
      m_s1  = dsd_on;
      m_ld  = lrck;
      m_st  = nst;
      m_tgt = ntgt;

      exp_q.push_back({3'(nst), m_path,
                       (nst == 2) || (nst == 3 && ntgt == 1),
                       (nst == 4),
                       !(nst == 2 || nst == 5),
                       (nst == 2),
                       ferr});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got st=%0d path=%b en=%b clr=%b mute=%b lock=%b ferr=%b exp st=%0d path=%b en=%b clr=%b mute=%b lock=%b ferr=%b",
                 $time, act[8:6], act[5], act[4], act[3], act[2], act[1], act[0],
                 e[8:6], e[5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- LRCK / DSD data driver ----------------
  int lr_mode = 0;      // 0 clean framing, 1 stuck, 2 random DSD data
  int short_cnt = 0;    // requested short halves (31 BCK)

  initial begin : lrck_drv
    int lcnt, cur_half, short_done;
    lcnt = 0; cur_half = HALF; short_done = 0;
    forever begin
      @(posedge clk);
      #1;
      case (lr_mode)
        0: begin
          lcnt++;
          if (lcnt >= cur_half) begin
            lrck = ~lrck;
            lcnt = 0;
            if (short_cnt != short_done) begin
              cur_half = HALF - 1;
              short_done++;
            end else begin
              cur_half = HALF;
            end
          end
        end
        1: lcnt = 0;
        default: lrck = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] want, input int budget, input string nm);
    int n;
    n = 0;
    while (state_o !== want && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (state_o !== want) begin
      errors++;
      $display("FAIL wait_%s: STATE=%0d want %0d after %0d cycles", nm, state_o, want, n);
    end
  endtask

  initial begin
    repeat (5) tick();
    rst_n = 1'b1;

    // clean framing: acquire, lock, clear, PCM run
    wait_state(3'd1, 5, "acquire");
    wait_state(3'd2, 2000, "pcm_lock");
    repeat (100) tick();

    // one short half: frame error, relock
    short_cnt++;
    wait_state(3'd1, 200, "short_err");
    wait_state(3'd2, 2000, "relock_short");
    repeat (50) tick();

    // stuck LRCK: timeout
    lr_mode = 1;
    wait_state(3'd1, 200, "timeout");
    lr_mode = 0;
    wait_state(3'd2, 2000, "relock_tmo");

    // PCM -> DSD -> PCM
    dsd_on = 1'b1;
    wait_state(3'd3, 20, "mute_to_dsd");
    wait_state(3'd5, 200, "dsd_run");
    lr_mode = 2;
    repeat (50) tick();
    dsd_on = 1'b0;
    lr_mode = 0;
    wait_state(3'd1, 200, "back_acquire");
    wait_state(3'd2, 2000, "pcm_again");

    // DSD_ON toggling during MUTE_DOWN is ignored until the RUN state
    dsd_on = 1'b1;
    wait_state(3'd3, 20, "mute_toggle");
    repeat (10) tick();
    dsd_on = 1'b0;
    repeat (10) tick();
    dsd_on = 1'b1;
    repeat (5) tick();
    dsd_on = 1'b0;
    wait_state(3'd5, 300, "dsd_after_toggle");
    wait_state(3'd3, 20, "rerequest_pcm");
    wait_state(3'd1, 200, "rerequest_acq");
    wait_state(3'd2, 2000, "rerequest_pcm_run");

    // randomised mode requests and framing faults
    for (int i = 0; i < 8; i++) begin
      dsd_on = 1'($urandom_range(0, 1));
      lr_mode = dsd_on ? 2 : 0;
      if ($urandom_range(0, 2) == 0) short_cnt++;
      repeat ($urandom_range(60, 500)) tick();
    end

    // reset in the middle of CLEAR
    dsd_on = 1'b0;
    lr_mode = 0;
    wait_state(3'd2, 3000, "pre_reset_pcm");
    dsd_on = 1'b1;
    wait_state(3'd4, 200, "clear_dsd");
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== RST_VEC) begin
      errors++;
      $display("FAIL async_reset: got %b exp %b", act, RST_VEC);
    end
    dsd_on = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    wait_state(3'd1, 5, "restart_acquire");
    wait_state(3'd2, 2000, "restart_pcm");
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_dsd_mode_ctrl.md
# i2s_dsd_mode_ctrl

Mode sequencer for the I2S/DSD front end. It watches the incoming LRCK framing and the asynchronous `DSD_ON` request. It then sequences the datapath between PCM operation (I2S deserialiser feeding the delta-sigma modulator) and DSD passthrough, with glitch-free mute, modulator clear and frame-lock supervision. It sits beside the datapath in `topLevel` and drives its path-select, enable, clear and mute controls.

## Interface
- `HALF_BCK`, 32: BCK cycles per LRCK half-period (one channel slot).
- `LOCK_HALVES`, 8: consecutive correct half-periods required to declare lock.
- `MUTE_CYCLES`, 64: mute ramp/settle time before any path change.
- `CLR_CYCLES`, 16: cycles `MOD_CLR` is held.
- `CNT_W`, 8: counter width; must satisfy 2^CNT_W > max(2*HALF_BCK, MUTE_CYCLES, CLR_CYCLES).

Ports:
- `I2S_BCKorDSDCLK`  in  1  sole clock, rising edge.
- `I2S_RST`  in  1  reset, asynchronous, active-low.
- `I2S_LRCKorDSD2`  in  1  LRCK in PCM mode (synchronous to BCK), DSD right data in DSD mode.
- `DSD_ON`  in  1  asynchronous mode request, 1 = DSD passthrough.
- `PATH_DSD`  out  1  datapath select, 1 = DSD passthrough.
- `MOD_EN`  out  1  modulator enable.
- `MOD_CLR`  out  1  modulator integrator clear.
- `MUTE`  out  1  output mute.
- `LOCKED`  out  1  PCM framing locked.
- `FRAME_ERR`  out  1  one-cycle pulse on framing loss.
- `STATE`  out  3  current state code.

## Operation
- `DSD_ON` passes through a 2-flop synchroniser (`req`). LRCK is used directly with a 1-cycle delayed copy. `edge` = LRCK differs from its delayed copy.
- Frame checker, active only in IDLE/ACQUIRE/PCM_RUN; otherwise held cleared:
  - `hcnt` resets to 0 on `edge` and increments otherwise, saturating.
  - The first edge after clear only sets `primed`.
  - A primed edge is good when `hcnt == HALF_BCK-1`; any other value is bad.
  - A timeout is `hcnt` reaching `2*HALF_BCK-1` without an edge; it counts as bad and clears `primed`.
  - `good` counts consecutive good edges, saturating at `LOCK_HALVES`, and is zeroed by any bad event.
- States, with the value shown on `STATE`:
  - IDLE (0): entered only from reset. Next cycle goes to CLEAR with target DSD if `req`=1, else to ACQUIRE.
  - ACQUIRE (1): goes to CLEAR with target PCM when `good == LOCK_HALVES`. If `req`=1, goes to CLEAR with target DSD, which has priority.
  - PCM_RUN (2): if `req`=1, goes to MUTE_DOWN with target DSD. On a bad event, goes to ACQUIRE, pulses `FRAME_ERR` and zeroes `good`. A bad event has priority over `req` in the same cycle.
  - MUTE_DOWN (3): waits `MUTE_CYCLES` cycles. Target DSD then goes to CLEAR; target PCM goes to ACQUIRE.
  - CLEAR (4): waits `CLR_CYCLES` cycles, then goes to PCM_RUN or DSD_RUN according to the target.
  - DSD_RUN (5): if `req`=0, goes to MUTE_DOWN with target PCM.
  - Codes 6 and 7 go to IDLE.
- Target is latched on entry to MUTE_DOWN or CLEAR. `req` is ignored outside IDLE, ACQUIRE and the two RUN states.
- Outputs are registered (Moore, decoded from the next state):
  - `MUTE`=0 only in PCM_RUN and DSD_RUN.
  - `MOD_EN`=1 in PCM_RUN, and in MUTE_DOWN when leaving PCM.
  - `MOD_CLR`=1 only in CLEAR.
  - `PATH_DSD` is updated on entry to CLEAR (target DSD) or ACQUIRE (0), and never changes while `MUTE`=0.
  - `LOCKED`=1 only in PCM_RUN.
- Reset values: state IDLE, `MUTE`=1 and all other outputs 0. Counters, `primed`, `good` and the synchroniser all clear. Reset asserted mid-sequence forces these values immediately.

## Timing
- `DSD_ON` to `STATE` change: 3 cycles (2 for the synchroniser, 1 registered).
- Dwell counters load on state entry. The state is held exactly `MUTE_CYCLES` or `CLR_CYCLES` cycles, including the entry cycle.
- `FRAME_ERR` and `MUTE` rise on the clock edge after the bad edge or timeout is detected.
- `MOD_CLR` low and `MUTE` low occur on the same edge at the end of CLEAR.

## Test plan
- Clean LRCK (toggle every 32 BCK), `DSD_ON`=0 after reset -> ACQUIRE. Lock on the 9th edge, then 16 cycles of CLEAR with `MOD_CLR`=1. Then PCM_RUN with `LOCKED`=1, `MUTE`=0, `MOD_EN`=1.
- In PCM_RUN, one LRCK half of 31 cycles -> `FRAME_ERR` pulses 1 cycle, `MUTE`=1, `LOCKED`=0, `STATE`=1. Relock needs 8 further good halves.
- In PCM_RUN, LRCK stuck for 64 cycles -> timeout, `FRAME_ERR`, return to ACQUIRE.
- In PCM_RUN, raise `DSD_ON` -> MUTE_DOWN for 64 cycles with `MOD_EN`=1, then CLEAR with `PATH_DSD`=1, then DSD_RUN with `MUTE`=0 and `MOD_EN`=0. Lowering `DSD_ON` -> MUTE_DOWN, then ACQUIRE with `PATH_DSD`=0.
- Toggle `DSD_ON` during MUTE_DOWN -> no effect until the RUN state is reached; the bench then checks the re-request.
- Assert `I2S_RST` low mid-CLEAR -> outputs are immediately at reset values; after release, sequencing restarts from IDLE.
